// File: rtl/trace_packer.sv
// trace_packer: per-warp slots collect issue + 0..3 writebacks and drain one trace record per cycle.
// Optional sticky bad-writeback flag on err when TRACE_PACKER_CHECK_EN is defined.
module trace_packer #(
  parameter int ARCH_LEN = 32,
  parameter int NUM_WARPS = 8,
  parameter int NUM_LANES = 16,
  parameter int REG_BITS = 8,
  localparam int WARP_ID_BITS = $clog2(NUM_WARPS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [ARCH_LEN-1:0]           issue_pc,
  input  logic [WARP_ID_BITS-1:0]       issue_warpId,
  input  logic [NUM_LANES-1:0]          issue_tmask,
  input  logic [1:0]                    issue_nregs,
  input  logic                          wb_valid,
  input  logic [WARP_ID_BITS-1:0]       wb_warpId,
  input  logic [REG_BITS-1:0]           wb_address,
  input  logic [NUM_LANES*ARCH_LEN-1:0] wb_data,
  output logic                          trace_valid,
  output logic [ARCH_LEN-1:0]           trace_pc,
  output logic [WARP_ID_BITS-1:0]       trace_warpId,
  output logic [NUM_LANES-1:0]          trace_tmask,
  output logic                          trace_regs_0_enable,
  output logic [REG_BITS-1:0]           trace_regs_0_address,
  output logic [NUM_LANES*ARCH_LEN-1:0] trace_regs_0_data,
  output logic                          trace_regs_1_enable,
  output logic [REG_BITS-1:0]           trace_regs_1_address,
  output logic [NUM_LANES*ARCH_LEN-1:0] trace_regs_1_data,
  output logic                          trace_regs_2_enable,
  output logic [REG_BITS-1:0]           trace_regs_2_address,
  output logic [NUM_LANES*ARCH_LEN-1:0] trace_regs_2_data,
  output logic                          err,
  output logic                          idle
);
  localparam int DW = NUM_LANES * ARCH_LEN;
  logic [NUM_WARPS-1:0]    busy;
  logic [ARCH_LEN-1:0]     pc_q    [NUM_WARPS];
  logic [NUM_LANES-1:0]    tmask_q [NUM_WARPS];
  logic [1:0]              nregs_q [NUM_WARPS];
  logic [1:0]              cnt_q   [NUM_WARPS];
  logic [REG_BITS-1:0]     addr_q  [NUM_WARPS][3];
  logic [DW-1:0]           data_q  [NUM_WARPS][3];
  logic [NUM_WARPS-1:0]    done;
  logic [WARP_ID_BITS-1:0] ptr, pick, idx;
  logic                    pick_valid, wb_ok;
  logic                    rec_en   [3];
  logic [REG_BITS-1:0]     rec_addr [3];
  logic [DW-1:0]           rec_data [3];
  logic                    t_en     [3];
  logic [REG_BITS-1:0]     t_addr   [3];
  logic [DW-1:0]           t_data   [3];
  assign issue_ready = !busy[issue_warpId];
  assign wb_ok = wb_valid && busy[wb_warpId] && cnt_q[wb_warpId] < nregs_q[wb_warpId];
  assign idle = !(|busy) && !trace_valid;
  // Scan backwards from ptr+N-1 to ptr so the last hit is the first complete slot at or after ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick = ptr;
    idx = ptr;
    for (int i = 0; i < NUM_WARPS; i++) done[i] = busy[i] && cnt_q[i] == nregs_q[i];
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      idx = WARP_ID_BITS'((int'(ptr) + i) % NUM_WARPS);
      if (done[idx]) begin
        pick_valid = 1'b1;
        pick = idx;
      end
    end
    for (int k = 0; k < 3; k++) begin
      rec_en[k] = 2'(k) < nregs_q[pick];
      rec_addr[k] = rec_en[k] ? addr_q[pick][k] : '0;
      rec_data[k] = rec_en[k] ? data_q[pick][k] : '0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
      ptr <= '0;
      trace_valid <= 1'b0;
      trace_pc <= '0;
      trace_warpId <= '0;
      trace_tmask <= '0;
      for (int k = 0; k < 3; k++) begin
        t_en[k] <= 1'b0;
        t_addr[k] <= '0;
        t_data[k] <= '0;
      end
    end else begin
      trace_valid <= pick_valid;
      if (wb_ok) begin
        addr_q[wb_warpId][cnt_q[wb_warpId]] <= wb_address;
        data_q[wb_warpId][cnt_q[wb_warpId]] <= wb_data;
        cnt_q[wb_warpId] <= cnt_q[wb_warpId] + 2'd1;
      end
      if (issue_valid && issue_ready) begin
        pc_q[issue_warpId] <= issue_pc;
        tmask_q[issue_warpId] <= issue_tmask;
        nregs_q[issue_warpId] <= issue_nregs;
        cnt_q[issue_warpId] <= 2'd0;
        busy[issue_warpId] <= 1'b1;
      end
      if (pick_valid) begin
        busy[pick] <= 1'b0;
        ptr <= pick == WARP_ID_BITS'(NUM_WARPS - 1) ? '0 : pick + 1'b1;
        trace_pc <= pc_q[pick];
        trace_warpId <= pick;
        trace_tmask <= tmask_q[pick];
        for (int k = 0; k < 3; k++) begin
          t_en[k] <= rec_en[k];
          t_addr[k] <= rec_addr[k];
          t_data[k] <= rec_data[k];
        end
      end
    end
  end
  assign trace_regs_0_enable = t_en[0];
  assign trace_regs_0_address = t_addr[0];
  assign trace_regs_0_data = t_data[0];
  assign trace_regs_1_enable = t_en[1];
  assign trace_regs_1_address = t_addr[1];
  assign trace_regs_1_data = t_data[1];
  assign trace_regs_2_enable = t_en[2];
  assign trace_regs_2_address = t_addr[2];
  assign trace_regs_2_data = t_data[2];
`ifdef TRACE_PACKER_CHECK_EN
  logic err_q;
  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else if (wb_valid && !wb_ok) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_trace_packer.sv
// tb_trace_packer: directed vectors with hand-computed records for trace_packer.
module tb_trace_packer;
  localparam int AL = 32, NW = 8, NL = 16, RB = 8, DW = NL * AL;
`ifdef TRACE_PACKER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  logic issue_valid = 1'b0, issue_ready;
  logic [AL-1:0] issue_pc = '0;
  logic [2:0] issue_warpId = '0;
  logic [NL-1:0] issue_tmask = '0;
  logic [1:0] issue_nregs = '0;
  logic wb_valid = 1'b0;
  logic [2:0] wb_warpId = '0;
  logic [RB-1:0] wb_address = '0;
  logic [DW-1:0] wb_data = '0;
  logic trace_valid;
  logic [AL-1:0] trace_pc;
  logic [2:0] trace_warpId;
  logic [NL-1:0] trace_tmask;
  logic r0_en, r1_en, r2_en;
  logic [RB-1:0] r0_a, r1_a, r2_a;
  logic [DW-1:0] r0_d, r1_d, r2_d;
  logic err, idle;
  int n_cmp = 0, n_bad = 0;

  trace_packer #(.ARCH_LEN(AL), .NUM_WARPS(NW), .NUM_LANES(NL), .REG_BITS(RB)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_pc(issue_pc),
    .issue_warpId(issue_warpId), .issue_tmask(issue_tmask), .issue_nregs(issue_nregs),
    .wb_valid(wb_valid), .wb_warpId(wb_warpId), .wb_address(wb_address), .wb_data(wb_data),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_warpId(trace_warpId),
    .trace_tmask(trace_tmask),
    .trace_regs_0_enable(r0_en), .trace_regs_0_address(r0_a), .trace_regs_0_data(r0_d),
    .trace_regs_1_enable(r1_en), .trace_regs_1_address(r1_a), .trace_regs_1_data(r1_d),
    .trace_regs_2_enable(r2_en), .trace_regs_2_address(r2_a), .trace_regs_2_data(r2_d),
    .err(err), .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] base);
    logic [DW-1:0] p;
    for (int g = 0; g < NL; g++) p[AL*g +: AL] = base + 32'(g);
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic iss(input int w, input logic [31:0] pc, input logic [15:0] tm, input int n);
    issue_valid = 1'b1;
    issue_warpId = 3'(w);
    issue_pc = pc;
    issue_tmask = tm;
    issue_nregs = 2'(n);
  endtask

  task automatic wb(input int w, input int a, input logic [31:0] base);
    wb_valid = 1'b1;
    wb_warpId = 3'(w);
    wb_address = 8'(a);
    wb_data = pat(base);
  endtask

  task automatic quiet();
    issue_valid = 1'b0;
    wb_valid = 1'b0;
  endtask

  task automatic rec(input string tag, input int w, input logic [31:0] pc, input logic [15:0] tm,
                     input int n, input int a0, input int a1, input int a2,
                     input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
    check({tag, ".valid"}, DW'(trace_valid), DW'(1));
    check({tag, ".warp"}, DW'(trace_warpId), DW'(w));
    check({tag, ".pc"}, DW'(trace_pc), DW'(pc));
    check({tag, ".tmask"}, DW'(trace_tmask), DW'(tm));
    check({tag, ".en0"}, DW'(r0_en), DW'(n > 0));
    check({tag, ".en1"}, DW'(r1_en), DW'(n > 1));
    check({tag, ".en2"}, DW'(r2_en), DW'(n > 2));
    check({tag, ".a0"}, DW'(r0_a), n > 0 ? DW'(a0) : '0);
    check({tag, ".a1"}, DW'(r1_a), n > 1 ? DW'(a1) : '0);
    check({tag, ".a2"}, DW'(r2_a), n > 2 ? DW'(a2) : '0);
    check({tag, ".d0"}, r0_d, n > 0 ? pat(b0) : '0);
    check({tag, ".d1"}, r1_d, n > 1 ? pat(b1) : '0);
    check({tag, ".d2"}, r2_d, n > 2 ? pat(b2) : '0);
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    check("rst.valid", DW'(trace_valid), '0);
    check("rst.ready", DW'(issue_ready), DW'(1));
    check("rst.idle", DW'(idle), DW'(1));
    check("rst.err", DW'(err), '0);
    check("rst.pc", DW'(trace_pc), '0);
    check("rst.en0", DW'(r0_en), '0);
    // single instruction, two writebacks
    iss(2, 32'h8000_0010, 16'hFFFF, 2);
    tick();
    quiet();
    check("single.busy", DW'(idle), '0);
    wb(2, 5, 32'h0500_0000);
    tick();
    wb(2, 7, 32'h0700_0000);
    tick();
    quiet();
    check("single.t1", DW'(trace_valid), '0);
    tick();
    rec("single", 2, 32'h8000_0010, 16'hFFFF, 2, 5, 7, 0, 32'h0500_0000, 32'h0700_0000, 0);
    tick();
    check("single.pulse", DW'(trace_valid), '0);
    check("single.idle", DW'(idle), DW'(1));
    // zero-register issue
    iss(0, 32'h100, 16'h1234, 0);
    tick();
    issue_valid = 1'b0;
    check("zero.ready_lo", DW'(issue_ready), '0);
    check("zero.t1", DW'(trace_valid), '0);
    tick();
    rec("zero", 0, 32'h100, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
    check("zero.ready_hi", DW'(issue_ready), DW'(1));
    tick();
    // round robin: warps 4..7 wait on one writeback each, warps 0..3 issue with zero regs
    for (int w = 4; w < 8; w++) begin
      iss(w, 32'h200 + 32'(w), 16'h00F0, 1);
      tick();
    end
    quiet();
    for (int j = 0; j < 4; j++) begin
      iss(j, 32'h200 + 32'(j), 16'h00F0, 0);
      wb(7 - j, 20 + j, 32'h2000_0000);
      tick();
      if (j == 1) check("rr.w7", DW'(trace_warpId), DW'(7));
      if (j == 2) check("rr.w0", DW'(trace_warpId), DW'(0));
      if (j == 3) check("rr.w1", DW'(trace_warpId), DW'(1));
      if (j > 0) check($sformatf("rr.v%0d", j), DW'(trace_valid), DW'(1));
    end
    quiet();
    for (int w = 2; w < 7; w++) begin
      tick();
      check($sformatf("rr.v_w%0d", w), DW'(trace_valid), DW'(1));
      check($sformatf("rr.w%0d", w), DW'(trace_warpId), DW'(w));
      check($sformatf("rr.pc%0d", w), DW'(trace_pc), DW'(32'h200 + 32'(w)));
    end
    tick();
    check("rr.drained", DW'(idle), DW'(1));
    // next batch: pointer sits at 7, so 7 beats 0
    iss(0, 32'h210, 16'h0001, 1);
    tick();
    iss(7, 32'h217, 16'h0080, 0);
    wb(0, 30, 32'h3000_0000);
    tick();
    quiet();
    tick();
    check("rr2.first", DW'(trace_warpId), DW'(7));
    check("rr2.v1", DW'(trace_valid), DW'(1));
    tick();
    rec("rr2.second", 0, 32'h210, 16'h0001, 1, 30, 0, 0, 32'h3000_0000, 0, 0);
    tick();
    // backpressure on warp 3
    iss(3, 32'h300, 16'h00FF, 1);
    tick();
    iss(3, 32'h333, 16'hAAAA, 0);
    check("bp.ready0", DW'(issue_ready), '0);
    tick();
    check("bp.ready1", DW'(issue_ready), '0);
    wb(3, 9, 32'h0900_0000);
    tick();
    wb_valid = 1'b0;
    check("bp.ready2", DW'(issue_ready), '0);
    tick();
    rec("bp.orig", 3, 32'h300, 16'h00FF, 1, 9, 0, 0, 32'h0900_0000, 0, 0);
    check("bp.ready_up", DW'(issue_ready), DW'(1));
    tick();
    issue_valid = 1'b0;
    check("bp.accepted", DW'(issue_ready), '0);
    tick();
    rec("bp.held", 3, 32'h333, 16'hAAAA, 0, 0, 0, 0, 0, 0, 0);
    tick();
    // bad writebacks
    wb(5, 1, 32'h5000_0000);
    tick();
    wb_valid = 1'b0;
    check("err.free", DW'(err), DW'(EXP_ERR));
    check("err.idle", DW'(idle), DW'(1));
    iss(4, 32'h400, 16'hF00F, 3);
    tick();
    issue_valid = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      wb(4, r, 32'h4000_0000 + 32'(r << 8));
      tick();
    end
    wb_valid = 1'b0;
    rec("err.rec", 4, 32'h400, 16'hF00F, 3, 1, 2, 3, 32'h4000_0100, 32'h4000_0200, 32'h4000_0300);
    check("err.sticky", DW'(err), DW'(EXP_ERR));
    tick();
    check("err.no_extra", DW'(trace_valid), '0);
    // reset mid-operation
    iss(1, 32'h500, 16'h0F0F, 2);
    tick();
    issue_valid = 1'b0;
    wb(1, 10, 32'h1000_0000);
    tick();
    wb_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid.idle", DW'(idle), DW'(1));
    check("mid.err", DW'(err), '0);
    check("mid.ready", DW'(issue_ready), DW'(1));
    tick();
    tick();
    check("mid.no_rec", DW'(trace_valid), '0);
    iss(1, 32'h600, 16'h3C3C, 2);
    tick();
    issue_valid = 1'b0;
    wb(1, 11, 32'h1100_0000);
    tick();
    wb(1, 12, 32'h1200_0000);
    tick();
    wb_valid = 1'b0;
    check("fresh.t1", DW'(trace_valid), '0);
    tick();
    rec("fresh", 1, 32'h600, 16'h3C3C, 2, 11, 12, 0, 32'h1100_0000, 32'h1200_0000, 0);
    tick();
    check("fresh.idle", DW'(idle), DW'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
